// File: rtl/npu_cmd_sequencer.sv
// Single-command sequencer behind the host MMIO register file: WRITE, READ,
// FILL of the unified buffer and compute RUN with timeout, plus status byte.
module npu_cmd_sequencer #(
  parameter int unsigned ADDR_WIDTH      = 16,
  parameter int unsigned BUFFER_WIDTH    = 64,
  parameter int unsigned ARG_WIDTH       = 32,
  parameter int unsigned HOST_DATA_WIDTH = 8,
  parameter int unsigned TIMEOUT_CYCLES  = 65535
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       doorbell,
  input  logic [HOST_DATA_WIDTH-1:0] cmd_in,
  input  logic [ADDR_WIDTH-1:0]      addr_in,
  input  logic [ARG_WIDTH-1:0]       arg_in,
  input  logic [BUFFER_WIDTH-1:0]    mmvr_in,
  output logic [HOST_DATA_WIDTH-1:0] status_out,
  output logic                       mem_req,
  output logic                       mem_we,
  output logic [ADDR_WIDTH-1:0]      mem_addr,
  output logic [BUFFER_WIDTH-1:0]    mem_wdata,
  input  logic                       mem_ready,
  input  logic                       mem_rvalid,
  input  logic [BUFFER_WIDTH-1:0]    mem_rdata,
  output logic [BUFFER_WIDTH-1:0]    readback_data,
  output logic                       compute_start,
  output logic [ARG_WIDTH-1:0]       compute_arg,
  input  logic                       compute_done
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [HOST_DATA_WIDTH-1:0] OP_WRITE = HOST_DATA_WIDTH'(1);
  localparam logic [HOST_DATA_WIDTH-1:0] OP_READ  = HOST_DATA_WIDTH'(2);
  localparam logic [HOST_DATA_WIDTH-1:0] OP_FILL  = HOST_DATA_WIDTH'(3);
  localparam logic [HOST_DATA_WIDTH-1:0] OP_RUN   = HOST_DATA_WIDTH'(4);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ_REQ,
    ST_READ_WAIT,
    ST_FILL,
    ST_RUN_START,
    ST_RUN_WAIT
  } state_e;

  state_e                    state_q, state_d;
  logic                      mem_req_q, mem_req_d;
  logic                      mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0]     mem_addr_q, mem_addr_d;
  logic [BUFFER_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
  logic [BUFFER_WIDTH-1:0]   readback_q, readback_d;
  logic                      compute_start_q, compute_start_d;
  logic [ARG_WIDTH-1:0]      compute_arg_q, compute_arg_d;
  logic [15:0]               fill_rem_q, fill_rem_d;
  logic [CNT_W-1:0]          wait_cnt_q, wait_cnt_d;
  logic                      done_q, done_d;
  logic                      err_cmd_q, err_cmd_d;
  logic                      err_overrun_q, err_overrun_d;
  logic                      err_timeout_q, err_timeout_d;
  logic                      busy;
  logic                      accept;

  assign busy   = (state_q != ST_IDLE);
  assign accept = mem_req_q & mem_ready;

  always_comb begin
    state_d         = state_q;
    mem_req_d       = mem_req_q;
    mem_we_d        = mem_we_q;
    mem_addr_d      = mem_addr_q;
    mem_wdata_d     = mem_wdata_q;
    readback_d      = readback_q;
    compute_start_d = 1'b0;
    compute_arg_d   = compute_arg_q;
    fill_rem_d      = fill_rem_q;
    wait_cnt_d      = wait_cnt_q;
    done_d          = done_q;
    err_cmd_d       = err_cmd_q;
    err_overrun_d   = err_overrun_q;
    err_timeout_d   = err_timeout_q;

    if (doorbell && busy) begin
      err_overrun_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (doorbell) begin
          done_d        = 1'b0;
          err_cmd_d     = 1'b0;
          err_overrun_d = 1'b0;
          err_timeout_d = 1'b0;
          // The memory-side registers double as the latched command operands.
          case (cmd_in)
            OP_WRITE: begin
              state_d     = ST_WRITE;
              mem_req_d   = 1'b1;
              mem_we_d    = 1'b1;
              mem_addr_d  = addr_in;
              mem_wdata_d = mmvr_in;
            end
            OP_READ: begin
              state_d    = ST_READ_REQ;
              mem_req_d  = 1'b1;
              mem_we_d   = 1'b0;
              mem_addr_d = addr_in;
            end
            OP_FILL: begin
              state_d     = ST_FILL;
              fill_rem_d  = arg_in[15:0];
              mem_req_d   = |arg_in[15:0];
              mem_we_d    = 1'b1;
              mem_addr_d  = addr_in;
              mem_wdata_d = mmvr_in;
            end
            OP_RUN: begin
              state_d         = ST_RUN_START;
              compute_start_d = 1'b1;
              compute_arg_d   = arg_in;
            end
            default: err_cmd_d = 1'b1;
          endcase
        end
      end

      ST_WRITE: begin
        if (accept) begin
          mem_req_d = 1'b0;
          state_d   = ST_IDLE;
          done_d    = 1'b1;
        end
      end

      ST_READ_REQ: begin
        if (accept) begin
          mem_req_d = 1'b0;
          state_d   = ST_READ_WAIT;
        end
      end

      ST_READ_WAIT: begin
        if (mem_rvalid) begin
          readback_d = mem_rdata;
          state_d    = ST_IDLE;
          done_d     = 1'b1;
        end
      end

      ST_FILL: begin
        if (fill_rem_q == 16'd0) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else if (accept) begin
          fill_rem_d = fill_rem_q - 16'd1;
          mem_addr_d = mem_addr_q + ADDR_WIDTH'(1);
          if (fill_rem_q == 16'd1) begin
            mem_req_d = 1'b0;
            state_d   = ST_IDLE;
            done_d    = 1'b1;
          end
        end
      end

      ST_RUN_START: begin
        wait_cnt_d = '0;
        state_d    = ST_RUN_WAIT;
      end

      ST_RUN_WAIT: begin
        if (compute_done) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else if (wait_cnt_q == TMO_LAST) begin
          state_d       = ST_IDLE;
          err_timeout_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      mem_req_q       <= 1'b0;
      mem_we_q        <= 1'b0;
      mem_addr_q      <= '0;
      mem_wdata_q     <= '0;
      readback_q      <= '0;
      compute_start_q <= 1'b0;
      compute_arg_q   <= '0;
      fill_rem_q      <= '0;
      wait_cnt_q      <= '0;
      done_q          <= 1'b0;
      err_cmd_q       <= 1'b0;
      err_overrun_q   <= 1'b0;
      err_timeout_q   <= 1'b0;
    end else begin
      state_q         <= state_d;
      mem_req_q       <= mem_req_d;
      mem_we_q        <= mem_we_d;
      mem_addr_q      <= mem_addr_d;
      mem_wdata_q     <= mem_wdata_d;
      readback_q      <= readback_d;
      compute_start_q <= compute_start_d;
      compute_arg_q   <= compute_arg_d;
      fill_rem_q      <= fill_rem_d;
      wait_cnt_q      <= wait_cnt_d;
      done_q          <= done_d;
      err_cmd_q       <= err_cmd_d;
      err_overrun_q   <= err_overrun_d;
      err_timeout_q   <= err_timeout_d;
    end
  end

  assign status_out    = HOST_DATA_WIDTH'({err_timeout_q, err_overrun_q, err_cmd_q, done_q, busy});
  assign mem_req       = mem_req_q;
  assign mem_we        = mem_we_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;
  assign readback_data = readback_q;
  assign compute_start = compute_start_q;
  assign compute_arg   = compute_arg_q;

endmodule

// File: tb/tb_npu_cmd_sequencer.sv
// Randomized bench for npu_cmd_sequencer: a transaction-level model predicts
// accepted transfers, status, readback and compute activity per command.
module tb_npu_cmd_sequencer;

  localparam int unsigned AW  = 16;
  localparam int unsigned BW  = 64;
  localparam int unsigned GW  = 32;
  localparam int unsigned HW  = 8;
  localparam int unsigned TMO = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          doorbell = 1'b0;
  logic [HW-1:0] cmd_in = '0;
  logic [AW-1:0] addr_in = '0;
  logic [GW-1:0] arg_in = '0;
  logic [BW-1:0] mmvr_in = '0;
  logic [HW-1:0] status_out;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [BW-1:0] mem_wdata;
  logic          mem_ready = 1'b0;
  logic          mem_rvalid = 1'b0;
  logic [BW-1:0] mem_rdata = '0;
  logic [BW-1:0] readback_data;
  logic          compute_start;
  logic [GW-1:0] compute_arg;
  logic          compute_done = 1'b0;

  always #5 clk = ~clk;

  npu_cmd_sequencer #(
    .ADDR_WIDTH     (AW),
    .BUFFER_WIDTH   (BW),
    .ARG_WIDTH      (GW),
    .HOST_DATA_WIDTH(HW),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .doorbell     (doorbell),
    .cmd_in       (cmd_in),
    .addr_in      (addr_in),
    .arg_in       (arg_in),
    .mmvr_in      (mmvr_in),
    .status_out   (status_out),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_ready    (mem_ready),
    .mem_rvalid   (mem_rvalid),
    .mem_rdata    (mem_rdata),
    .readback_data(readback_data),
    .compute_start(compute_start),
    .compute_arg  (compute_arg),
    .compute_done (compute_done)
  );

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [BW-1:0] data;
  } xfer_t;

  int n_checks = 0;
  int n_errors = 0;

  logic [BW-1:0] mem_model [0:65535];
  logic [BW-1:0] rb_model;
  logic [GW-1:0] arg_model;

  xfer_t acc_q[$];
  int    ready_pat[$];
  int    ready_pct = 100;
  bit    launching = 1'b0;
  bit    rd_pending = 1'b0;
  int    rd_wait = 0;
  int    rd_delay = 1;
  logic [BW-1:0] rd_data_next;
  bit    run_armed = 1'b0;
  int    run_cnt = 0;
  int    run_delay = 0;
  int    req_cycles = 0;
  int    start_cycles = 0;
  logic [GW-1:0] start_arg;
  bit    hold_prev = 1'b0;
  logic [AW+BW:0] hold_val;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive the memory/compute responders, observe the DUT at
  // the negedge (stable), then advance to the next negedge.
  task automatic cycle();
    if (!rst_n) mem_ready = 1'b0;
    else if (ready_pat.size() > 0 && !launching) mem_ready = (ready_pat.pop_front() != 0);
    else mem_ready = ($urandom_range(99) < ready_pct);

    mem_rvalid = 1'b0;
    mem_rdata  = {$urandom, $urandom};
    if (rd_pending) begin
      if (rd_wait == 0) begin
        mem_rvalid = 1'b1;
        mem_rdata  = rd_data_next;
        rd_pending = 1'b0;
      end else begin
        rd_wait--;
      end
    end else if ($urandom_range(7) == 0) begin
      mem_rvalid = 1'b1;
    end

    compute_done = 1'b0;
    if (run_armed) begin
      run_cnt++;
      if (run_cnt == run_delay) begin
        compute_done = 1'b1;
        run_armed    = 1'b0;
      end
    end

    if (hold_prev) begin
      check_eq("hold_req", mem_req, 1'b1);
      check_eq("hold_xfer", {mem_we, mem_addr, mem_wdata}, hold_val);
    end

    if (mem_req) req_cycles++;
    if (mem_req && mem_ready && rst_n) begin
      acc_q.push_back('{mem_we, mem_addr, mem_wdata});
      if (mem_we) mem_model[mem_addr] = mem_wdata;
      else begin
        rd_pending   = 1'b1;
        rd_wait      = rd_delay - 1;
        rd_data_next = mem_model[mem_addr];
      end
    end
    if (compute_start) begin
      start_cycles++;
      start_arg = compute_arg;
      if (!run_armed && run_delay > 0) begin
        run_armed = 1'b1;
        run_cnt   = 0;
      end
    end

    hold_prev = mem_req && !mem_ready && rst_n;
    hold_val  = {mem_we, mem_addr, mem_wdata};
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    doorbell = 1'b0;
    cycle();
    cycle();
    rst_n      = 1'b1;
    rd_pending = 1'b0;
    run_armed  = 1'b0;
    hold_prev  = 1'b0;
    rb_model   = '0;
    arg_model  = '0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_status"}, status_out, 8'h00);
    check_eq({tag, "_mem_req"}, mem_req, 1'b0);
    check_eq({tag, "_mem_we"}, mem_we, 1'b0);
    check_eq({tag, "_mem_addr"}, mem_addr, '0);
    check_eq({tag, "_mem_wdata"}, mem_wdata, '0);
    check_eq({tag, "_readback"}, readback_data, '0);
    check_eq({tag, "_cstart"}, compute_start, 1'b0);
    check_eq({tag, "_carg"}, compute_arg, '0);
  endtask

  task automatic launch(input logic [HW-1:0] cmd, input logic [AW-1:0] addr,
                        input logic [GW-1:0] arg, input logic [BW-1:0] mmvr);
    acc_q.delete();
    req_cycles   = 0;
    start_cycles = 0;
    run_armed    = 1'b0;
    cmd_in = cmd; addr_in = addr; arg_in = arg; mmvr_in = mmvr;
    doorbell  = 1'b1;
    launching = 1'b1;
    cycle();
    doorbell  = 1'b0;
    launching = 1'b0;
    cmd_in  = HW'($urandom);
    addr_in = AW'($urandom);
    arg_in  = $urandom;
    mmvr_in = {$urandom, $urandom};
  endtask

  task automatic run_cmd(input logic [HW-1:0] cmd, input logic [AW-1:0] addr,
                         input logic [GW-1:0] arg, input logic [BW-1:0] mmvr,
                         input bit overrun);
    xfer_t exp_q[$];
    bit legal, timeout;
    logic [HW-1:0] exp_status;
    int cycles;
    legal   = cmd inside {8'h01, 8'h02, 8'h03, 8'h04};
    timeout = (cmd == 8'h04) && (run_delay <= 0 || run_delay > int'(TMO));
    case (cmd)
      8'h01: exp_q.push_back('{1'b1, addr, mmvr});
      8'h02: begin
        exp_q.push_back('{1'b0, addr, '0});
        rb_model = mem_model[addr];
      end
      8'h03: for (int i = 0; i < int'(arg[15:0]); i++) exp_q.push_back('{1'b1, AW'(addr + i), mmvr});
      8'h04: arg_model = arg;
      default: ;
    endcase
    if (!legal) exp_status = 8'h04;
    else exp_status = (timeout ? 8'h10 : 8'h02) | (overrun ? 8'h08 : 8'h00);

    launch(cmd, addr, arg, mmvr);
    check_eq("status_launch", status_out, legal ? 8'h01 : 8'h04);

    cycles = 0;
    while (status_out[0] && cycles < 500) begin
      if (overrun && cycles == 0) begin
        doorbell = 1'b1;
        cmd_in   = 8'h01;
      end
      cycle();
      doorbell = 1'b0;
      cycles++;
    end
    if (!legal) begin
      cycle();
      cycle();
    end
    check_eq("cmd_complete", status_out[0], 1'b0);
    check_eq("status_final", status_out, exp_status);
    check_eq("xfer_count", acc_q.size(), exp_q.size());
    foreach (exp_q[i]) begin
      if (i < acc_q.size()) begin
        check_eq("xfer_we", acc_q[i].we, exp_q[i].we);
        check_eq("xfer_addr", acc_q[i].addr, exp_q[i].addr);
        if (exp_q[i].we) check_eq("xfer_data", acc_q[i].data, exp_q[i].data);
      end
    end
    if (exp_q.size() == 0) check_eq("no_mem_req", req_cycles, 0);
    check_eq("mem_req_end", mem_req, 1'b0);
    check_eq("start_pulses", start_cycles, (cmd == 8'h04) ? 1 : 0);
    if (cmd == 8'h04) begin
      check_eq("start_arg", start_arg, arg);
      check_eq("run_busy_cycles", cycles, 1 + (timeout ? int'(TMO) : run_delay));
    end
    check_eq("compute_arg", compute_arg, arg_model);
    check_eq("readback", readback_data, rb_model);
  endtask

  initial begin
    logic [HW-1:0] cmd;
    logic [AW-1:0] addr;
    logic [GW-1:0] arg;
    int sel;
    bit ovr;

    for (int i = 0; i < 65536; i++) mem_model[i] = '0;
    @(negedge clk);
    do_reset();
    check_outputs_zero("reset");

    ready_pct = 100;
    run_cmd(8'h01, 16'h0010, 32'h0, 64'hDEADBEEF_CAFEF00D, 1'b0);

    mem_model[16'h0040] = 64'h1122334455667788;
    rd_delay = 3;
    run_cmd(8'h02, 16'h0040, 32'h0, 64'h0, 1'b0);
    check_eq("readback_plan", readback_data, 64'h1122334455667788);

    ready_pat = '{1, 0, 1, 1, 1};
    run_cmd(8'h03, 16'hFFFE, 32'd4, 64'hA5A5_0000_FFFF_5A5A, 1'b0);
    run_cmd(8'h03, 16'h1234, 32'd0, 64'h1, 1'b0);

    run_delay = 10;
    run_cmd(8'h04, 16'h0, 32'h0000_0005, 64'h0, 1'b0);
    run_delay = 0;
    run_cmd(8'h04, 16'h0, 32'h0000_0077, 64'h0, 1'b0);
    run_delay = 16;
    run_cmd(8'h04, 16'h0, 32'h0000_0099, 64'h0, 1'b0);

    run_cmd(8'h7F, 16'h0020, 32'h3, 64'h5, 1'b0);
    ready_pct = 70;
    run_cmd(8'h03, 16'h0100, 32'd5, 64'h0BAD_F00D_1234_5678, 1'b1);

    ready_pct = 100;
    launch(8'h03, 16'h0200, 32'd8, 64'h7777_8888_9999_AAAA);
    cycle();
    cycle();
    rst_n = 1'b0;
    cycle();
    check_eq("midreset_mem_req", mem_req, 1'b0);
    check_eq("midreset_status", status_out, 8'h00);
    rst_n      = 1'b1;
    rd_pending = 1'b0;
    run_armed  = 1'b0;
    hold_prev  = 1'b0;
    rb_model   = '0;
    arg_model  = '0;
    check_eq("midreset_readback", readback_data, '0);
    run_cmd(8'h01, 16'h0300, 32'h0, 64'h0123_4567_89AB_CDEF, 1'b0);
    rd_delay = 1;
    run_cmd(8'h02, 16'h0300, 32'h0, 64'h0, 1'b0);

    for (int n = 0; n < 60; n++) begin
      sel = $urandom_range(5);
      case (sel)
        0: cmd = 8'h01;
        1: cmd = 8'h02;
        2: cmd = 8'h03;
        3: cmd = 8'h04;
        4: cmd = 8'h02;
        default: cmd = HW'(5 + $urandom_range(250));
      endcase
      addr = ($urandom_range(1) == 0) ? AW'($urandom) : AW'(16'hFFFC + $urandom_range(7));
      arg  = (cmd == 8'h03) ? GW'($urandom_range(6)) : GW'($urandom);
      ready_pct = $urandom_range(40, 100);
      rd_delay  = $urandom_range(1, 4);
      run_delay = $urandom_range(0, 20);
      ovr = (cmd inside {8'h01, 8'h02, 8'h03, 8'h04}) && ($urandom_range(3) == 0);
      run_cmd(cmd, addr, arg, {$urandom, $urandom}, ovr);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
